sd_request_arbiter: RTL
=======================

Name: sd_request_arbiter

Overview:
- Parametrised successor to the single-drive HDD request/ack sequencer in the emu top level.
- Latches read/write sector requests from NUM_CH virtual drives (floppy 1/2, HDD, future slots) and round-robin arbitrates them onto one shared hps_io sd_rd/sd_wr/sd_ack channel.
- Holds a per-channel CPU wait and reports completion/error per request.
- Adds behaviour the old sequencer lacks: write-protect rejection, unmounted-drive rejection, ack timeout and a fair grant order.

Parameters:
- NUM_CH, 3, number of requesting channels (1..8).
- LBA_W, 32, sector address width per channel.
- TIMEOUT_W, 24, width of the ack-wait counter; timeout fires at 2^TIMEOUT_W-1 cycles without an ack rise.

Ports:
- clk_sys  in  1  system clock (14 MHz domain).
- reset  in  1  synchronous, active-high.
- req_rd  in  NUM_CH  one-cycle read request pulse per channel.
- req_wr  in  NUM_CH  one-cycle write request pulse per channel.
- req_lba  in  NUM_CH*LBA_W  sector per channel (ch c at [c*LBA_W +: LBA_W]); sampled at grant.
- mounted  in  NUM_CH  image present per channel.
- protect  in  NUM_CH  image read-only per channel.
- sd_lba  out  NUM_CH*LBA_W  per-channel LBA presented to hps_io.
- sd_rd  out  NUM_CH  per-channel read strobe to hps_io.
- sd_wr  out  NUM_CH  per-channel write strobe to hps_io.
- sd_ack  in  NUM_CH  per-channel ack from hps_io.
- cpu_wait  out  NUM_CH  stall to the requesting controller.
- done  out  NUM_CH  one-cycle pulse on successful completion.
- err  out  NUM_CH  one-cycle pulse on rejection or timeout.
- grant_ch  out  3  index of the currently serviced channel (valid when busy).
- busy  out  1  arbiter not idle.

Behaviour:
- Reset values: all outputs 0; pend_rd/pend_wr, counter and rr pointer cleared; state IDLE. Reset wins over every other event, including an ack in flight. Reset mid-transfer drops sd_rd/sd_wr the next cycle and abandons the request; no done or err is raised.
- Pending latch:
  - pend_rd[c] |= req_rd[c] and pend_wr[c] |= req_wr[c] every cycle.
  - A request arriving in the same cycle its channel's pending bit is cleared is retained (set wins over clear).
- cpu_wait[c]: registered, = pend_rd[c] | pend_wr[c] | (active and grant_ch==c). It rises one cycle after the request pulse and falls one cycle after the completion event.
- States:
  - IDLE: if any channel is pending, grant the first pending channel at or after rr_ptr (wrapping modulo NUM_CH). Capture its LBA into the sd_lba slice and set grant_ch. Go to CHECK.
  - CHECK (1 cycle):
    - If !mounted[g]: clear both pend bits, pulse err[g], go to IDLE.
    - Else if pend_wr[g] & protect[g]: clear pend_wr[g] only, pulse err[g], go to IDLE.
    - Else assert sd_wr[g] if pend_wr[g], otherwise sd_rd[g]; a write takes priority and a simultaneous read stays pending. Clear counter, go to REQ.
  - REQ: the counter increments.
    - On sd_ack[g] rise: deassert sd_rd/sd_wr, clear the serviced pend bit, go to XFER.
    - If the counter reaches all-ones first: deassert strobe, clear the serviced pend bit, pulse err[g], go to IDLE.
  - XFER: on sd_ack[g] fall, pulse done[g] and go to IDLE. There is no timeout in XFER.
- rr_ptr = grant_ch+1 (wrapping) on every exit to IDLE.
- busy = state != IDLE. At most one sd_rd/sd_wr bit is ever high.
- Edge detect uses a registered copy of sd_ack[g].
- Latency for an idle channel with a request pulse at cycle t: pend at t+1, CHECK at t+2, strobe visible at t+3.
- Non-granted sd_lba slices hold their last captured value.

Test Plan:
- Ch1 read, LBA 0x12 → sd_rd[1]=1 at t+3, sd_lba[1]=0x12. Ack rises at t+6 → sd_rd drops at t+7. Ack falls at t+10 → done[1] pulse at t+11, cpu_wait[1] low at t+11.
- Simultaneous read pulses on ch0, ch1, ch2 with rr_ptr=1 → service order 1, 2, 0; each waits for the previous done; cpu_wait stays high on all three until each channel's own done.
- Ch2 write with protect[2]=1 → err[2] pulse, sd_wr never asserted. Same with mounted[2]=0 → err[2], both pend bits cleared.
- TIMEOUT_W=4, ch0 read, sd_ack held 0 → err[0] after 15 REQ cycles, sd_rd[0] low, busy low next cycle.
- Ch0 read and write pulsed in the same cycle → write serviced first (sd_wr[0]), then read (sd_rd[0]); two done pulses.
- Reset asserted while in XFER → sd_rd/sd_wr, cpu_wait, busy all 0 next cycle; no done/err; a new request afterwards is serviced normally.

Source files
------------

// File: rtl/sd_request_arbiter.sv
// Round-robin arbiter that multiplexes sector read/write requests from several
// virtual drives onto one hps_io sd_rd/sd_wr/sd_ack handshake.
module sd_request_arbiter #(
  parameter int NUM_CH    = 3,
  parameter int LBA_W     = 32,
  parameter int TIMEOUT_W = 24
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req_rd,
  input  logic [NUM_CH-1:0]       req_wr,
  input  logic [NUM_CH*LBA_W-1:0] req_lba,
  input  logic [NUM_CH-1:0]       mounted,
  input  logic [NUM_CH-1:0]       protect,
  output logic [NUM_CH*LBA_W-1:0] sd_lba,
  output logic [NUM_CH-1:0]       sd_rd,
  output logic [NUM_CH-1:0]       sd_wr,
  input  logic [NUM_CH-1:0]       sd_ack,
  output logic [NUM_CH-1:0]       cpu_wait,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       err,
  output logic [2:0]              grant_ch,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, CHECK, REQ, XFER} state_e;

  state_e                   state_q, state_d;
  logic [NUM_CH-1:0]        pend_rd_q, pend_rd_d;
  logic [NUM_CH-1:0]        pend_wr_q, pend_wr_d;
  logic [NUM_CH-1:0]        clr_rd, clr_wr;
  logic [TIMEOUT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [2:0]               rr_q, rr_d;
  logic [2:0]               grant_q, grant_d;
  logic                     wr_sel_q, wr_sel_d;
  logic [NUM_CH-1:0]        sd_rd_q, sd_rd_d;
  logic [NUM_CH-1:0]        sd_wr_q, sd_wr_d;
  logic [NUM_CH*LBA_W-1:0]  sd_lba_q, sd_lba_d;
  logic [NUM_CH-1:0]        ack_prev_q;
  logic [NUM_CH-1:0]        cpu_wait_q, cpu_wait_d;
  logic [NUM_CH-1:0]        done_q, done_d;
  logic [NUM_CH-1:0]        err_q, err_d;

  logic [NUM_CH-1:0]        pend_any;
  logic [NUM_CH-1:0]        grant_oh, grant_oh_d;
  logic                     found;
  logic [2:0]               pick;
  logic                     g_mounted, g_protect, g_pend_wr, g_ack, g_ack_prev;
  logic                     ack_rise, ack_fall, cnt_to;

  assign pend_any = pend_rd_q | pend_wr_q;
  assign cnt_inc  = cnt_q + 1'b1;
  assign cnt_to   = (cnt_inc == '1);
  assign ack_rise = g_ack & ~g_ack_prev;
  assign ack_fall = ~g_ack & g_ack_prev;

  // Pick the first pending channel at or after rr_q, then wrap to the low channels.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && pend_any[c] && (3'(c) >= rr_q)) begin
        found = 1'b1;
        pick  = 3'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && pend_any[c]) begin
        found = 1'b1;
        pick  = 3'(c);
      end
    end
  end

  always_comb begin
    g_mounted  = 1'b0;
    g_protect  = 1'b0;
    g_pend_wr  = 1'b0;
    g_ack      = 1'b0;
    g_ack_prev = 1'b0;
    grant_oh   = '0;
    grant_oh_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == 3'(c)) begin
        g_mounted   = mounted[c];
        g_protect   = protect[c];
        g_pend_wr   = pend_wr_q[c];
        g_ack       = sd_ack[c];
        g_ack_prev  = ack_prev_q[c];
        grant_oh[c] = 1'b1;
      end
      if (grant_d == 3'(c)) begin
        grant_oh_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (found) state_d = CHECK;
      CHECK: begin
        if (!g_mounted || (g_pend_wr && g_protect)) state_d = IDLE;
        else                                        state_d = REQ;
      end
      REQ: begin
        if (ack_rise)    state_d = XFER;
        else if (cnt_to) state_d = IDLE;
      end
      XFER:  if (ack_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_rd   = '0;
    clr_wr   = '0;
    grant_d  = grant_q;
    rr_d     = rr_q;
    wr_sel_d = wr_sel_q;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;
    sd_lba_d = sd_lba_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          for (int c = 0; c < NUM_CH; c++) begin
            if (pick == 3'(c)) sd_lba_d[c*LBA_W +: LBA_W] = req_lba[c*LBA_W +: LBA_W];
          end
        end
      end
      CHECK: begin
        if (!g_mounted) begin
          clr_rd = grant_oh;
          clr_wr = grant_oh;
          err_d  = grant_oh;
        end else if (g_pend_wr && g_protect) begin
          clr_wr = grant_oh;
          err_d  = grant_oh;
        end else begin
          wr_sel_d = g_pend_wr;
          if (g_pend_wr) sd_wr_d = grant_oh;
          else           sd_rd_d = grant_oh;
          cnt_d = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (ack_rise || cnt_to) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          if (wr_sel_q) clr_wr = grant_oh;
          else          clr_rd = grant_oh;
          if (!ack_rise) err_d = grant_oh;
        end
      end
      XFER: begin
        if (ack_fall) done_d = grant_oh;
      end
      default: ;
    endcase

    if ((state_q != IDLE) && (state_d == IDLE)) begin
      rr_d = (grant_q == 3'(NUM_CH-1)) ? 3'd0 : grant_q + 3'd1;
    end

    // New request pulses are OR-ed in after clearing so a same-cycle set survives.
    pend_rd_d  = (pend_rd_q & ~clr_rd) | req_rd;
    pend_wr_d  = (pend_wr_q & ~clr_wr) | req_wr;
    cpu_wait_d = pend_rd_d | pend_wr_d | ((state_d != IDLE) ? grant_oh_d : '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      wr_sel_q   <= 1'b0;
      sd_rd_q    <= '0;
      sd_wr_q    <= '0;
      sd_lba_q   <= '0;
      ack_prev_q <= '0;
      cpu_wait_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      wr_sel_q   <= wr_sel_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      sd_lba_q   <= sd_lba_d;
      ack_prev_q <= sd_ack;
      cpu_wait_q <= cpu_wait_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sd_lba   = sd_lba_q;
  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign cpu_wait = cpu_wait_q;
  assign done     = done_q;
  assign err      = err_q;
  assign grant_ch = grant_q;
  assign busy     = (state_q != IDLE);

endmodule
